// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous memory port between the instruction-fetch path (if_*) and the
// load/store path (ls_*). One transaction is in flight at a time. Simultaneous requests
// are resolved round-robin against the last owner. Read data returns MEM_LAT cycles
// after the mem_en cycle and is handed back to the owning requester with a one-cycle
// rvalid pulse.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   if_req/if_addr         fetch request (read only), held until if_gnt
//   if_gnt/if_rvalid       one-cycle pulses: issued / if_rdata valid
//   if_rdata               last fetch read data
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request, held until ls_gnt
//   ls_gnt/ls_rvalid       one-cycle pulses: issued / ls_rdata valid (loads only)
//   ls_rdata               last load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory request (registered)
//   mem_rdata              memory read data
//   busy                   arbiter is not idle
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   localparam logic       OwnIf  = 1'b0;
   localparam logic       OwnLs  = 1'b1;
   localparam logic [3:0] LatCnt = 4'(MEM_LAT);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_owner_q, last_owner_d;
   logic              we_q, we_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              sel;

   logic              if_gnt_d, ls_gnt_d, if_rvalid_d, ls_rvalid_d, mem_en_d, mem_we_d;
   logic [DATA_W-1:0] if_rdata_d, ls_rdata_d, mem_wdata_d;
   logic [ADDR_W-1:0] mem_addr_d;

   // Outputs are registered, so they are computed from the state being entered.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      if_gnt_d     = 1'b0;
      ls_gnt_d     = 1'b0;
      if_rvalid_d  = 1'b0;
      ls_rvalid_d  = 1'b0;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      if_rdata_d   = if_rdata;
      ls_rdata_d   = ls_rdata;
      // Contention goes to whoever did not own the port last.
      sel          = (if_req && ls_req) ? ~last_owner_q : ls_req;

      unique case (state_q)
         StIdle: begin
            if (if_req || ls_req) begin
               owner_d  = sel;
               state_d  = StIssue;
               mem_en_d = 1'b1;
               if (sel == OwnLs) begin
                  we_d        = ls_we;
                  mem_we_d    = ls_we;
                  mem_addr_d  = ls_addr;
                  mem_wdata_d = ls_wdata;
                  ls_gnt_d    = 1'b1;
               end else begin
                  we_d        = 1'b0;
                  mem_addr_d  = if_addr;
                  if_gnt_d    = 1'b1;
               end
            end
         end
         StIssue: begin
            last_owner_d = owner_q;
            if (we_q) begin
               state_d = StIdle;
            end else begin
               state_d = StWait;
               cnt_d   = 4'd1;
            end
         end
         StWait: begin
            if (cnt_q == LatCnt) begin
               state_d = StResp;
               if (owner_q == OwnLs) begin
                  ls_rdata_d  = mem_rdata;
                  ls_rvalid_d = 1'b1;
               end else begin
                  if_rdata_d  = mem_rdata;
                  if_rvalid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= OwnIf;
         last_owner_q <= OwnLs;
         we_q         <= 1'b0;
         cnt_q        <= 4'd0;
         if_gnt       <= 1'b0;
         ls_gnt       <= 1'b0;
         if_rvalid    <= 1'b0;
         ls_rvalid    <= 1'b0;
         if_rdata     <= '0;
         ls_rdata     <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         cnt_q        <= cnt_d;
         if_gnt       <= if_gnt_d;
         ls_gnt       <= ls_gnt_d;
         if_rvalid    <= if_rvalid_d;
         ls_rvalid    <= ls_rvalid_d;
         if_rdata     <= if_rdata_d;
         ls_rdata     <= ls_rdata_d;
         mem_en       <= mem_en_d;
         mem_we       <= mem_we_d;
         mem_addr     <= mem_addr_d;
         mem_wdata    <= mem_wdata_d;
      end
   end

   assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance a has MEM_LAT=1, instance b has MEM_LAT=3.
// Both share the requester inputs; each has its own memory model whose read data is
// valid only in the exact cycle MEM_LAT after the mem_en cycle.
module tb_mem_port_arbiter;

   logic        clk, rst;
   logic        if_req, ls_req, ls_we;
   logic [31:0] if_addr, ls_addr, ls_wdata;

   logic        a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_en, a_mem_we, a_busy;
   logic [31:0] a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we, b_busy;
   logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [31:0] b_p0, b_p1;

   int checks = 0;
   int failures = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
      .if_rdata(a_if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut_b (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
      .if_rdata(b_if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      case (a)
         32'h100: return 32'hE3A01005;
         32'h200: return 32'h12345678;
         default: return a ^ 32'hA5A5A5A5;
      endcase
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read data appears only in the single cycle it is due; otherwise garbage.
   always @(posedge clk) begin
      a_mem_rdata <= (a_mem_en && !a_mem_we) ? memf(a_mem_addr) : 32'hBAD0BAD0;
      b_p0        <= (b_mem_en && !b_mem_we) ? memf(b_mem_addr) : 32'hBAD0BAD0;
      b_p1        <= b_p0;
      b_mem_rdata <= b_p1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({a_if_gnt, a_if_rvalid, a_ls_gnt, a_ls_rvalid, a_mem_en, a_mem_we, a_busy, a_if_rdata,
           a_ls_rdata, a_mem_addr, a_mem_wdata} !== '0) begin
         failures++; $display("FAIL reset_a outputs not all zero");
      end
      checks++;
      if ({b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_en, b_mem_we, b_busy, b_if_rdata,
           b_ls_rdata, b_mem_addr, b_mem_wdata} !== '0) begin
         failures++; $display("FAIL reset_b outputs not all zero");
      end
   endtask

   task automatic test_single_fetch();
      do_reset();
      if_req = 1'b1; if_addr = 32'h100;
      tick();  // T+1
      checks++;
      if ({a_if_gnt, a_ls_gnt, a_mem_en, a_mem_we, a_busy} !== 5'b10101) begin
         failures++; $display("FAIL fetch_gnt got %b exp 10101",
                              {a_if_gnt, a_ls_gnt, a_mem_en, a_mem_we, a_busy});
      end
      checks++;
      if (a_mem_addr !== 32'h100) begin
         failures++; $display("FAIL fetch_addr got %h exp 00000100", a_mem_addr);
      end
      if_req = 1'b0;
      tick();  // T+2
      checks++;
      if ({a_if_gnt, a_mem_en, a_if_rvalid} !== 3'b000) begin
         failures++; $display("FAIL fetch_wait got %b exp 000", {a_if_gnt, a_mem_en, a_if_rvalid});
      end
      tick();  // T+3
      checks++;
      if (a_if_rvalid !== 1'b1 || a_if_rdata !== 32'hE3A01005) begin
         failures++; $display("FAIL fetch_rvalid got %b/%h exp 1/e3a01005", a_if_rvalid, a_if_rdata);
      end
      tick();  // T+4
      checks++;
      if (a_busy !== 1'b0 || a_if_rvalid !== 1'b0 || a_if_rdata !== 32'hE3A01005) begin
         failures++; $display("FAIL fetch_done got busy=%b rv=%b rd=%h exp 0/0/e3a01005",
                              a_busy, a_if_rvalid, a_if_rdata);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      if_req = 1'b1; if_addr = 32'h300;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
      tick();  // T+1
      checks++;
      if ({a_if_gnt, a_ls_gnt} !== 2'b10 || a_mem_addr !== 32'h300) begin
         failures++; $display("FAIL sim_first got gnt=%b addr=%h exp 10/00000300",
                              {a_if_gnt, a_ls_gnt}, a_mem_addr);
      end
      if_req = 1'b0;
      tick(); tick();  // T+3
      checks++;
      if ({a_if_rvalid, a_ls_rvalid} !== 2'b10 || a_if_rdata !== memf(32'h300) ||
          a_ls_rdata !== 32'h0) begin
         failures++; $display("FAIL sim_if_resp got rv=%b if=%h ls=%h exp 10/%h/0",
                              {a_if_rvalid, a_ls_rvalid}, a_if_rdata, a_ls_rdata, memf(32'h300));
      end
      tick(); tick();  // T+5
      checks++;
      if ({a_if_gnt, a_ls_gnt} !== 2'b01 || a_mem_addr !== 32'h200) begin
         failures++; $display("FAIL sim_second got gnt=%b addr=%h exp 01/00000200",
                              {a_if_gnt, a_ls_gnt}, a_mem_addr);
      end
      ls_req = 1'b0;
      tick(); tick();  // T+7
      checks++;
      if ({a_if_rvalid, a_ls_rvalid} !== 2'b01 || a_ls_rdata !== 32'h12345678 ||
          a_if_rdata !== memf(32'h300)) begin
         failures++; $display("FAIL sim_ls_resp got rv=%b if=%h ls=%h exp 01/%h/12345678",
                              {a_if_rvalid, a_ls_rvalid}, a_if_rdata, a_ls_rdata, memf(32'h300));
      end
   endtask

   task automatic test_contention();
      logic got [6];
      int   n = 0;
      bit   both = 1'b0;
      do_reset();
      if_req = 1'b1; if_addr = 32'h100;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
      for (int c = 0; c < 60 && n < 6; c++) begin
         tick();
         if (a_if_gnt && a_ls_gnt) both = 1'b1;
         if (a_if_gnt || a_ls_gnt) begin
            got[n] = a_ls_gnt;
            n++;
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      checks++;
      if (n != 6) begin
         failures++; $display("FAIL rr_timeout got %0d grants exp 6", n);
      end
      checks++;
      if (both) begin
         failures++; $display("FAIL rr_double_grant got both gnts high exp one");
      end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got[i] !== logic'(i % 2)) begin
            failures++; $display("FAIL rr_order[%0d] got ls=%b exp ls=%0d", i, got[i], i % 2);
         end
      end
      tick(); tick(); tick(); tick();
   endtask

   task automatic test_store();
      bit rv = 1'b0;
      do_reset();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hDEADBEEF;
      tick();  // T+1
      checks++;
      if ({a_ls_gnt, a_if_gnt, a_mem_en, a_mem_we} !== 4'b1011 || a_mem_addr !== 32'h40 ||
          a_mem_wdata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL store_issue got %b addr=%h wd=%h exp 1011/00000040/deadbeef",
                              {a_ls_gnt, a_if_gnt, a_mem_en, a_mem_we}, a_mem_addr, a_mem_wdata);
      end
      ls_req = 1'b0; ls_we = 1'b0;
      tick();  // T+2
      checks++;
      if ({a_busy, a_mem_en, a_mem_we} !== 3'b000) begin
         failures++; $display("FAIL store_idle got %b exp 000", {a_busy, a_mem_en, a_mem_we});
      end
      for (int i = 0; i < 4; i++) begin
         if (a_ls_rvalid || a_if_rvalid) rv = 1'b1;
         tick();
      end
      checks++;
      if (rv) begin
         failures++; $display("FAIL store_rvalid got rvalid exp none");
      end
   endtask

   task automatic test_latency3();
      bit early = 1'b0;
      do_reset();
      if_req = 1'b1; if_addr = 32'h100;
      tick();  // T+1
      checks++;
      if (b_if_gnt !== 1'b1) begin
         failures++; $display("FAIL lat3_gnt got %b exp 1", b_if_gnt);
      end
      if_req = 1'b0;
      tick();  // T+2
      if_req = 1'b1; if_addr = 32'h180;
      for (int i = 0; i < 3; i++) begin  // T+2..T+4
         if (b_if_gnt || b_if_rvalid) early = 1'b1;
         if (i < 2) tick();
      end
      checks++;
      if (early) begin
         failures++; $display("FAIL lat3_holdoff got gnt/rvalid before T+5 exp none");
      end
      tick();  // T+5
      checks++;
      if (b_if_rvalid !== 1'b1 || b_if_rdata !== 32'hE3A01005 || b_if_gnt !== 1'b0) begin
         failures++; $display("FAIL lat3_rvalid got rv=%b rd=%h gnt=%b exp 1/e3a01005/0",
                              b_if_rvalid, b_if_rdata, b_if_gnt);
      end
      tick();  // T+6
      checks++;
      if (b_if_gnt !== 1'b0) begin
         failures++; $display("FAIL lat3_resp_gnt got %b exp 0", b_if_gnt);
      end
      tick();  // T+7
      checks++;
      if (b_if_gnt !== 1'b1 || b_mem_addr !== 32'h180) begin
         failures++; $display("FAIL lat3_regrant got gnt=%b addr=%h exp 1/00000180",
                              b_if_gnt, b_mem_addr);
      end
      if_req = 1'b0;
   endtask

   task automatic test_reset_midop();
      bit rv = 1'b0;
      do_reset();
      if_req = 1'b1; if_addr = 32'h100;
      tick(); if_req = 1'b0;
      repeat (5) tick();  // T+6, idle with if_rdata = e3a01005
      if_req = 1'b1; if_addr = 32'h300;
      tick(); if_req = 1'b0;
      tick();  // WAIT
      checks++;
      if (b_busy !== 1'b1 || b_if_rdata !== 32'hE3A01005) begin
         failures++; $display("FAIL rst_pre got busy=%b rd=%h exp 1/e3a01005", b_busy, b_if_rdata);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({b_mem_en, b_busy} !== 2'b00 || b_if_rdata !== 32'h0) begin
         failures++; $display("FAIL rst_wait got en/busy=%b rd=%h exp 00/0",
                              {b_mem_en, b_busy}, b_if_rdata);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (b_if_rvalid || b_ls_rvalid) rv = 1'b1;
      end
      checks++;
      if (rv) begin
         failures++; $display("FAIL rst_discard got rvalid exp none");
      end
      if_req = 1'b1; if_addr = 32'h100;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
      tick();
      checks++;
      if ({b_if_gnt, b_ls_gnt} !== 2'b10) begin
         failures++; $display("FAIL rst_priority got %b exp 10", {b_if_gnt, b_ls_gnt});
      end
      if_req = 1'b0; ls_req = 1'b0;
      // Reset during ISSUE of a store must drop mem_en/mem_we at once.
      do_reset();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h44; ls_wdata = 32'h1;
      tick();
      ls_req = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({b_mem_en, b_mem_we, a_mem_en, a_mem_we} !== 4'b0000) begin
         failures++; $display("FAIL rst_issue got %b exp 0000",
                              {b_mem_en, b_mem_we, a_mem_en, a_mem_we});
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_contention();
      test_store();
      test_latency3();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
